// File: rtl/instruction_decode_stage_if.sv
// Handshake bundle for the LEGv8 decode stage: the upstream instruction
// port, the downstream decoded-entry port and the pipeline flush.
// The slave modport is the decode stage; the master modport is its environment.
interface instruction_decode_stage_if #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 64
) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [3:0]        out_class;
  logic [4:0]        out_rd;
  logic [4:0]        out_rn;
  logic [4:0]        out_rm;
  logic [DATA_W-1:0] out_imm;
  logic              out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_class, out_rd, out_rn, out_rm,
           out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_class, out_rd, out_rn, out_rm,
           out_imm, out_illegal
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// LEGv8 instruction decode stage: decodes the incoming word combinationally
// and stores the decoded entry in a small FIFO whose head drives the outputs.
// Optional feature: define DECODE_ILLEGAL_CNT_EN to build the saturating
// illegal-instruction counter; otherwise illegal_count is tied to zero.
module instruction_decode_stage #(
  parameter int DATA_W     = 64,
  parameter int PC_W       = 64,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  instruction_decode_stage_if.slave   bus,
  output logic [CNT_W-1:0]            illegal_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [3:0]        cls;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [DATA_W-1:0] imm;
    logic              illegal;
  } entry_t;

  entry_t          mem [0:FIFO_DEPTH-1];
  entry_t          dec;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [10:0]     op;
  logic            push;
  logic            pop;

  assign op   = bus.in_instr[31:21];
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready;

  // Decode the incoming word into class, register fields and immediate.
  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.rd      = bus.in_instr[4:0];
    dec.rn      = bus.in_instr[9:5];
    dec.rm      = bus.in_instr[20:16];
    casez (op)
      11'h458: dec.cls = 4'd1;
      11'h450: dec.cls = 4'd2;
      11'b1001000100?: begin
        dec.cls = 4'd3;
        dec.imm = {{(DATA_W-12){1'b0}}, bus.in_instr[21:10]};
      end
      11'b000101?????: begin
        dec.cls = 4'd4;
        dec.imm = {{(DATA_W-28){bus.in_instr[25]}}, bus.in_instr[25:0], 2'b00};
      end
      11'b01010100???: begin
        dec.cls = 4'd5;
        dec.imm = {{(DATA_W-21){bus.in_instr[23]}}, bus.in_instr[23:5], 2'b00};
      end
      11'h6B0: dec.cls = 4'd6;
      11'h650: dec.cls = 4'd7;
      11'h7C2: begin
        dec.cls = 4'd8;
        dec.imm = {{(DATA_W-9){bus.in_instr[20]}}, bus.in_instr[20:12]};
      end
      11'h5C4: begin
        dec.cls = 4'd9;
        dec.imm = {{(DATA_W-9){bus.in_instr[20]}}, bus.in_instr[20:12]};
      end
      11'h69B: begin
        dec.cls = 4'd10;
        dec.imm = {{(DATA_W-6){1'b0}}, bus.in_instr[15:10]};
      end
      11'h550: dec.cls = 4'd11;
      11'h7C0: begin
        dec.cls = 4'd12;
        dec.imm = {{(DATA_W-9){bus.in_instr[20]}}, bus.in_instr[20:12]};
      end
      11'h5C0: begin
        dec.cls = 4'd13;
        dec.imm = {{(DATA_W-9){bus.in_instr[20]}}, bus.in_instr[20:12]};
      end
      11'h658: dec.cls = 4'd14;
      11'h758: dec.cls = 4'd15;
      // An all-zero word is a NOP; anything else unmatched is illegal.
      default: dec.illegal = (bus.in_instr != 32'd0);
    endcase
  end

  // Entry FIFO: flush clears occupancy and blocks the push, and wins over pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The head slot is only written by a push, which cannot target it while it
  // holds valid data, so the outputs stay stable under backpressure.
  assign head            = mem[rd_ptr];
  assign bus.in_ready    = (count < DEPTH_C);
  assign bus.out_valid   = (count != '0);
  assign bus.out_pc      = head.pc;
  assign bus.out_class   = head.cls;
  assign bus.out_rd      = head.rd;
  assign bus.out_rn      = head.rn;
  assign bus.out_rm      = head.rm;
  assign bus.out_imm     = head.imm;
  assign bus.out_illegal = head.illegal;

`ifdef DECODE_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt_q;

  // Count accepted illegal words, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt_q <= '0;
    end else if (push && dec.illegal && (illegal_cnt_q != '1)) begin
      illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
    end
  end

  assign illegal_count = illegal_cnt_q;
`else
  assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: hand-computed decode results,
// backpressure ordering, flush and reset behaviour.
module tb_instruction_decode_stage;

  localparam int DATA_W = 64;
  localparam int PC_W   = 64;
  localparam int CNT_W  = 16;
`ifdef DECODE_ILLEGAL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] illegal_count;
  int               n_cmp;
  int               n_err;

  instruction_decode_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  instruction_decode_stage #(
    .DATA_W(DATA_W), .PC_W(PC_W), .FIFO_DEPTH(2), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one word for exactly one edge, then withdraw it.
  task automatic push_word(input logic [31:0] instr, input logic [63:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [3:0] cls, input logic [4:0] rd,
                          input logic [4:0] rn, input logic [4:0] rm, input logic [63:0] imm,
                          input logic ill, input logic [63:0] pc);
    chk({tag, ".valid"},   64'(bus.out_valid),   64'd1);
    chk({tag, ".class"},   64'(bus.out_class),   64'(cls));
    chk({tag, ".rd"},      64'(bus.out_rd),      64'(rd));
    chk({tag, ".rn"},      64'(bus.out_rn),      64'(rn));
    chk({tag, ".rm"},      64'(bus.out_rm),      64'(rm));
    chk({tag, ".imm"},     bus.out_imm,          imm);
    chk({tag, ".illegal"}, 64'(bus.out_illegal), 64'(ill));
    chk({tag, ".pc"},      bus.out_pc,           pc);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst.out_valid", 64'(bus.out_valid),     64'd0);
    chk("rst.in_ready",  64'(bus.in_ready),      64'd1);
    chk("rst.class",     64'(bus.out_class),     64'd0);
    chk("rst.rd",        64'(bus.out_rd),        64'd0);
    chk("rst.rn",        64'(bus.out_rn),        64'd0);
    chk("rst.rm",        64'(bus.out_rm),        64'd0);
    chk("rst.imm",       bus.out_imm,            64'd0);
    chk("rst.pc",        bus.out_pc,             64'd0);
    chk("rst.illegal",   64'(bus.out_illegal),   64'd0);
    chk("rst.cnt",       64'(illegal_count),     64'd0);

    // Single-entry decode, one per cycle with out_ready held high
    bus.out_ready = 1'b1;
    push_word(32'h8B020023, 64'h100);
    chk_head("add", 4'd1, 5'd3, 5'd1, 5'd2, 64'd0, 1'b0, 64'h100);
    chk("add.in_ready", 64'(bus.in_ready), 64'd1);

    push_word(32'hF85F8045, 64'h104);
    chk_head("ldur", 4'd8, 5'd5, 5'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h104);

    push_word(32'h17FFFFFF, 64'h108);
    chk_head("b", 4'd4, 5'd31, 5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h108);

    push_word(32'h00000000, 64'h10C);
    chk_head("nop", 4'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 64'h10C);

    push_word(32'h91203C00, 64'h110);
    chk_head("andi", 4'd3, 5'd0, 5'd0, 5'd0, 64'h80F, 1'b0, 64'h110);

    push_word(32'h5400006B, 64'h114);
    chk_head("bcond", 4'd5, 5'd11, 5'd3, 5'd0, 64'hC, 1'b0, 64'h114);

    push_word(32'hD3601422, 64'h118);
    chk_head("lsl", 4'd10, 5'd2, 5'd1, 5'd0, 64'd5, 1'b0, 64'h118);

    push_word(32'hEB030041, 64'h11C);
    chk_head("subs", 4'd15, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0, 64'h11C);

    // Illegal words
    push_word(32'hFFFFFFFF, 64'h120);
    chk_head("ill1", 4'd0, 5'd31, 5'd31, 5'd31, 64'd0, 1'b1, 64'h120);
    chk("ill1.cnt", 64'(illegal_count), CNT_ON ? 64'd1 : 64'd0);
    push_word(32'hFFFFFFFF, 64'h124);
    chk("ill2.illegal", 64'(bus.out_illegal), 64'd1);
    chk("ill2.cnt", 64'(illegal_count), CNT_ON ? 64'd2 : 64'd0);
    tick();
    chk("drain.out_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: three back-to-back words, only two fit
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h8B020023;
    bus.in_pc     = 64'h200;
    tick();
    chk("bp1.in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp1.pc",       bus.out_pc,        64'h200);
    bus.in_instr = 32'hCA000000;
    bus.in_pc    = 64'h204;
    tick();
    chk("bp2.in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp2.pc",       bus.out_pc,        64'h200);
    bus.in_instr = 32'hAA000000;
    bus.in_pc    = 64'h208;
    tick();
    chk("bp3.in_ready", 64'(bus.in_ready),  64'd0);
    chk("bp3.pc",       bus.out_pc,         64'h200);
    chk("bp3.class",    64'(bus.out_class), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("bp4.pc",       bus.out_pc,         64'h204);
    chk("bp4.class",    64'(bus.out_class), 64'd7);
    chk("bp4.in_ready", 64'(bus.in_ready),  64'd1);
    tick();
    chk("bp5.pc",        bus.out_pc,         64'h208);
    chk("bp5.class",     64'(bus.out_class), 64'd11);
    chk("bp5.out_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("bp6.out_valid", 64'(bus.out_valid), 64'd0);

    // Flush while full with an illegal word offered
    bus.out_ready = 1'b0;
    push_word(32'h8B020023, 64'h300);
    push_word(32'hCB000000, 64'h304);
    chk("fl.full", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFFFFFFFF;
    bus.in_pc    = 64'h308;
    bus.flush    = 1'b1;
    tick();
    chk("fl.out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl.in_ready",  64'(bus.in_ready),  64'd1);
    chk("fl.cnt",       64'(illegal_count), CNT_ON ? 64'd2 : 64'd0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("fl.dropped", 64'(bus.out_valid), 64'd0);

    // Reset overrides a concurrent push
    push_word(32'h8B020023, 64'h400);
    chk("rs.pre_valid", 64'(bus.out_valid), 64'd1);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFFFFFFFF;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("rs.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rs.in_ready",  64'(bus.in_ready),  64'd1);
    chk("rs.cnt",       64'(illegal_count), 64'd0);
    chk("rs.class",     64'(bus.out_class), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 Parameter DATA_W, 64: width of the sign-extended immediate output.
REQ-002 Parameter PC_W, 64: width of the PC carried alongside each instruction.
REQ-003 Parameter FIFO_DEPTH, 2: decoded-entry buffer depth, power of two, >=2.
REQ-004 Parameter CNT_W, 16: illegal-instruction counter width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream instruction present.
REQ-008 in_ready  output  1  stage accepts the instruction this cycle.
REQ-009 in_instr  input  32  LEGv8 instruction word.
REQ-010 in_pc  input  PC_W  PC of in_instr.
REQ-011 flush  input  1  discard all buffered and incoming instructions.
REQ-012 out_valid  output  1  decoded entry at FIFO head.
REQ-013 out_ready  input  1  downstream consumes the head entry.
REQ-014 out_pc  output  PC_W  PC of head entry.
REQ-015 out_class  output  4  0 NOP/illegal, 1 ADD, 2 AND, 3 ANDI, 4 B, 5 B.cond, 6 BR, 7 EOR, 8 LDUR, 9 LDURSW, 10 LSL, 11 ORR, 12 STUR, 13 STURW, 14 SUB, 15 SUBS.
REQ-016 out_rd, out_rn, out_rm  output  5 each  instr[4:0] (Rd/Rt/cond), instr[9:5], instr[20:16].
REQ-017 out_imm  output  DATA_W  extended immediate of head entry.
REQ-018 out_illegal  output  1  head entry is an unrecognised nonzero word.
REQ-019 illegal_count  output  CNT_W  number of illegal instructions accepted.

Function
REQ-020 Opcode instr[31:21] SHALL map: 0x458 ADD, 0x450 AND, 0x488-0x489 ANDI, 0x0A0-0x0BF B, 0x2A0-0x2A7 B.cond, 0x6B0 BR, 0x650 EOR, 0x7C2 LDUR, 0x5C4 LDURSW, 0x69B LSL, 0x550 ORR, 0x7C0 STUR, 0x5C0 STURW, 0x658 SUB, 0x758 SUBS.
REQ-021 Immediates: ANDI instr[21:10] zero-extended; D-type instr[20:12] sign-extended; B instr[25:0] sign-extended then <<2; B.cond instr[23:5] sign-extended then <<2; LSL instr[15:10] zero-extended; all others 0.
REQ-022 in_instr==0: class 0, illegal 0; any other unmatched word: class 0, illegal 1, imm 0.
REQ-023 Push occurs when in_valid && in_ready && !flush; pop when out_valid && out_ready.
REQ-024 in_ready SHALL be 1 iff occupancy < FIFO_DEPTH, from registered state only (no combinational path from out_ready).
REQ-025 Entry accepted at edge N SHALL appear on outputs by cycle N+1 if FIFO was empty; FIFO order preserved.
REQ-026 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 Output fields SHALL be held stable while out_valid && !out_ready.
REQ-028 flush SHALL empty the FIFO at the next edge, block any push that cycle, and take priority over pop.
REQ-029 illegal_count increments on each pushed illegal entry (even if later flushed), saturating at 2^CNT_W-1.

Reset
REQ-030 reset SHALL, at the next edge, empty the FIFO and zero illegal_count, overriding flush and handshakes.
REQ-031 After reset: out_valid 0, in_ready 1, out_class/rd/rn/rm/imm/pc/illegal all 0.

Configuration
REQ-032 Macro DECODE_ILLEGAL_CNT_EN defined: illegal counter built per REQ-029.
REQ-033 Macro undefined: no counter register; illegal_count tied to 0; out_illegal still produced.

Verification
REQ-034 Push 0x8B020023, out_ready=1 -> next cycle class 1, rd 3, rn 1, rm 2, imm 0.
REQ-035 Push 0xF85F8045 (LDUR X5,[X2,#-8]) -> class 8, rd 5, rn 2, imm 0xFFFF_FFFF_FFFF_FFF8.
REQ-036 Push 0x17FFFFFF -> class 4, imm -4; push 0x00000000 -> class 0, illegal 0.
REQ-037 out_ready=0, push 3 words back-to-back -> two accepted, in_ready=0 on third; release -> two entries emerge in order, third then accepted.
REQ-038 Push 0xFFFFFFFF twice -> out_illegal 1 each, illegal_count 2 (0 without DECODE_ILLEGAL_CNT_EN).
REQ-039 FIFO full, in_valid=1, flush=1 -> next cycle out_valid 0, in_ready 1, incoming word dropped.
